rsp_s2_dma_outs_mc: RTL and testbench

Multi-channel AXI outstanding-transaction tracker for the rsp_s2 DMA, one counter set per AXI ID/channel. It counts issued commands against returned responses per channel and flags full and empty per channel. It runs a saturating per-channel response-timeout watchdog and reports protocol errors (overflow/underflow) as sticky flags. It sits between the DMA command issue logic and the AXI response path, and gates issue per channel.

---
 rtl/rsp_s2_dma_outs_mc.sv | 85 ++++++++
 tb/tb_rsp_s2_dma_outs_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rsp_s2_dma_outs_mc.sv
// rsp_s2_dma_outs_mc: per-channel AXI outstanding tracker with watchdog and sticky protocol errors
module rsp_s2_dma_outs_mc #(
   parameter int CH_NUM       = 4,
   parameter int CH_BITS      = 2,
   parameter int OUT_BITS     = 8,
   parameter int TIMEOUT_BITS = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [TIMEOUT_BITS-1:0]      timeout_cnt,
   input  logic [OUT_BITS-1:0]          outs_max,
   input  logic                         timeout_en,
   input  logic                         cmd,
   input  logic [CH_BITS-1:0]           cmd_ch,
   input  logic                         clr,
   input  logic [CH_BITS-1:0]           clr_ch,
   input  logic                         err_clr,
   output logic [CH_NUM*OUT_BITS-1:0]   outs,
   output logic [CH_NUM-1:0]            outs_empty,
   output logic [CH_NUM-1:0]            outs_full,
   output logic                         all_empty,
   output logic [CH_NUM-1:0]            timeout,
   output logic                         ovf_err,
   output logic                         udf_err,
   output logic [CH_BITS-1:0]           err_ch
);
   logic [CH_NUM-1:0][OUT_BITS-1:0] cnt;
   logic [TIMEOUT_BITS-1:0]         tmr [CH_NUM];
   logic [CH_NUM-1:0]               hit_cmd, hit_clr;
   logic                            ovf_ev, udf_ev;

   assign outs      = cnt;
   assign all_empty = &outs_empty;

   // decode events per channel; out-of-range channels match nothing and are dropped
   always_comb begin
      hit_cmd    = '0;
      hit_clr    = '0;
      outs_empty = '0;
      outs_full  = '0;
      ovf_ev     = 1'b0;
      udf_ev     = 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
         hit_cmd[i]    = cmd && (cmd_ch == CH_BITS'(i));
         hit_clr[i]    = clr && (clr_ch == CH_BITS'(i));
         outs_empty[i] = cnt[i] == '0;
         outs_full[i]  = cnt[i] >= outs_max;
         ovf_ev        = ovf_ev | (hit_cmd[i] && !hit_clr[i] && outs_full[i]);
         udf_ev        = udf_ev | (hit_clr[i] && !hit_cmd[i] && outs_empty[i]);
      end
   end

   // counters, watchdogs and sticky error capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         timeout <= '0;
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
         err_ch  <= '0;
         for (int i = 0; i < CH_NUM; i++) tmr[i] <= timeout_cnt;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (hit_cmd[i] && !hit_clr[i] && cnt[i] != '1)
               cnt[i] <= cnt[i] + OUT_BITS'(1);
            else if (hit_clr[i] && !hit_cmd[i] && !outs_empty[i])
               cnt[i] <= cnt[i] - OUT_BITS'(1);
            tmr[i] <= (hit_clr[i] || outs_empty[i] || !timeout_en) ? timeout_cnt :
                      (tmr[i] == '0) ? tmr[i] : tmr[i] - TIMEOUT_BITS'(1);
            timeout[i] <= hit_clr[i] ? 1'b0 :
                          timeout[i] | (tmr[i] == '0 && !outs_empty[i] && timeout_en);
         end
         if (err_clr) begin
            ovf_err <= ovf_ev;
            udf_err <= udf_ev;
            err_ch  <= ovf_ev ? cmd_ch : udf_ev ? clr_ch : '0;
         end else begin
            ovf_err <= ovf_err | ovf_ev;
            udf_err <= udf_err | udf_ev;
            if (!ovf_err && !udf_err && (ovf_ev || udf_ev))
               err_ch <= ovf_ev ? cmd_ch : clr_ch;
         end
      end
   end
endmodule

// File: tb/tb_rsp_s2_dma_outs_mc.sv
// tb_rsp_s2_dma_outs_mc: directed scoreboard bench for the outstanding tracker
module tb_rsp_s2_dma_outs_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] timeout_cnt = 24'd5;
   logic [7:0]  outs_max = 8'd3;
   logic        timeout_en = 1'b0;
   logic        cmd = 1'b0, clr = 1'b0, err_clr = 1'b0;
   logic [1:0]  cmd_ch = '0, clr_ch = '0;
   logic [31:0] outs;
   logic [3:0]  outs_empty, outs_full, timeout;
   logic        all_empty, ovf_err, udf_err;
   logic [1:0]  err_ch;

   localparam int S_OUTS = 0, S_EMPTY = 1, S_FULL = 2, S_ALLE = 3, S_TO = 4, S_OVF = 5, S_UDF = 6, S_ERRCH = 7;

   typedef struct {
      string       name;
      int          due;
      int          sel;
      logic [31:0] v;
   } chk_t;

   chk_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   rsp_s2_dma_outs_mc dut (
      .clk(clk), .rst(rst), .timeout_cnt(timeout_cnt), .outs_max(outs_max),
      .timeout_en(timeout_en), .cmd(cmd), .cmd_ch(cmd_ch), .clr(clr), .clr_ch(clr_ch),
      .err_clr(err_clr), .outs(outs), .outs_empty(outs_empty), .outs_full(outs_full),
      .all_empty(all_empty), .timeout(timeout), .ovf_err(ovf_err), .udf_err(udf_err),
      .err_ch(err_ch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] act(input int s);
      case (s)
         S_OUTS:  return outs;
         S_EMPTY: return 32'(outs_empty);
         S_FULL:  return 32'(outs_full);
         S_ALLE:  return 32'(all_empty);
         S_TO:    return 32'(timeout);
         S_OVF:   return 32'(ovf_err);
         S_UDF:   return 32'(udf_err);
         default: return 32'(err_ch);
      endcase
   endfunction

   // monitor: pops every expectation due at this cycle and compares it
   initial forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
         chk_t c;
         c = q.pop_front();
         n_checks++;
         if (c.due != cyc || act(c.sel) !== c.v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (due %0d at %0d)", c.name, act(c.sel), c.v, c.due, cyc);
         end
      end
   end

   task automatic drive(input logic c, input int cc, input logic r, input int rc, input logic ec = 1'b0);
      @(negedge clk);
      cmd = c;
      cmd_ch = 2'(cc);
      clr = r;
      clr_ch = 2'(rc);
      err_clr = ec;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0);
   endtask

   task automatic exp(input string n, input int s, input logic [31:0] v);
      q.push_back('{n, cyc + 1, s, v});
   endtask

   task automatic exp_reset(input string n);
      exp({n, "_outs"}, S_OUTS, 32'h0);
      exp({n, "_empty"}, S_EMPTY, 32'hF);
      exp({n, "_alle"}, S_ALLE, 32'h1);
      exp({n, "_full"}, S_FULL, 32'h0);
      exp({n, "_to"}, S_TO, 32'h0);
      exp({n, "_ovf"}, S_OVF, 32'h0);
      exp({n, "_udf"}, S_UDF, 32'h0);
      exp({n, "_errch"}, S_ERRCH, 32'h0);
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      exp_reset("rst");
      @(negedge clk);
      rst = 1'b0;
      idle(10);
      exp_reset("idle");
      // fill ch2 to the limit, then overflow it
      drive(1'b1, 2, 1'b0, 0);
      drive(1'b1, 2, 1'b0, 0);
      exp("ch2_two_notfull", S_FULL, 32'h0);
      drive(1'b1, 2, 1'b0, 0);
      exp("ch2_full", S_FULL, 32'h4);
      exp("ch2_three", S_OUTS, 32'h0003_0000);
      drive(1'b1, 2, 1'b0, 0);
      exp("ch2_ovf_cnt", S_OUTS, 32'h0004_0000);
      exp("ch2_ovf", S_OVF, 32'h1);
      exp("ch2_errch", S_ERRCH, 32'h2);
      exp("ch2_noudf", S_UDF, 32'h0);
      drive(1'b0, 0, 1'b0, 0, 1'b1);
      exp("errclr_ovf", S_OVF, 32'h0);
      exp("errclr_errch", S_ERRCH, 32'h0);
      for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b1, 2);
      exp("drain2_outs", S_OUTS, 32'h0);
      exp("drain2_udf", S_UDF, 32'h0);
      // simultaneous cmd/clr on the same channel, empty then full
      drive(1'b1, 1, 1'b1, 1);
      exp("same_empty_outs", S_OUTS, 32'h0);
      exp("same_empty_udf", S_UDF, 32'h0);
      for (int i = 0; i < 3; i++) drive(1'b1, 1, 1'b0, 0);
      exp("ch1_full", S_FULL, 32'h2);
      drive(1'b1, 1, 1'b1, 1);
      exp("same_full_outs", S_OUTS, 32'h0000_0300);
      exp("same_full_ovf", S_OVF, 32'h0);
      // independent cmd ch0 and clr ch3
      drive(1'b1, 3, 1'b0, 0);
      drive(1'b1, 3, 1'b0, 0);
      drive(1'b1, 0, 1'b1, 3);
      exp("split_outs", S_OUTS, 32'h0100_0301);
      exp("split_alle", S_ALLE, 32'h0);
      exp("split_empty", S_EMPTY, 32'h4);
      drive(1'b0, 0, 1'b1, 0);
      for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1, 1);
      drive(1'b0, 0, 1'b1, 3);
      exp("drain_all", S_OUTS, 32'h0);
      exp("drain_alle", S_ALLE, 32'h1);
      // watchdog with reload 5
      timeout_en = 1'b1;
      idle(1);
      drive(1'b1, 1, 1'b0, 0);
      exp("wd_c0", S_TO, 32'h0);
      idle(5);
      exp("wd_c5", S_TO, 32'h0);
      idle(1);
      exp("wd_c6", S_TO, 32'h2);
      idle(3);
      exp("wd_hold", S_TO, 32'h2);
      drive(1'b0, 0, 1'b1, 1);
      exp("wd_clr_to", S_TO, 32'h0);
      exp("wd_clr_outs", S_OUTS, 32'h0);
      // watchdog with reload 0
      timeout_cnt = 24'd0;
      idle(1);
      drive(1'b1, 0, 1'b0, 0);
      exp("wd0_c0", S_TO, 32'h0);
      idle(1);
      exp("wd0_c1", S_TO, 32'h1);
      drive(1'b0, 0, 1'b1, 0);
      exp("wd0_clr", S_TO, 32'h0);
      timeout_en = 1'b0;
      timeout_cnt = 24'd5;
      // underflow first, then overflow keeps err_ch
      drive(1'b0, 0, 1'b1, 0);
      exp("udf0", S_UDF, 32'h1);
      exp("udf0_errch", S_ERRCH, 32'h0);
      exp("udf0_outs", S_OUTS, 32'h0);
      for (int i = 0; i < 4; i++) drive(1'b1, 3, 1'b0, 0);
      exp("ovf3", S_OVF, 32'h1);
      exp("ovf3_errch", S_ERRCH, 32'h0);
      exp("ovf3_outs", S_OUTS, 32'h0400_0000);
      drive(1'b0, 0, 1'b0, 0, 1'b1);
      exp("clr_ovf", S_OVF, 32'h0);
      exp("clr_udf", S_UDF, 32'h0);
      exp("clr_errch", S_ERRCH, 32'h0);
      drive(1'b1, 3, 1'b0, 0, 1'b1);
      exp("clrwin_ovf", S_OVF, 32'h1);
      exp("clrwin_errch", S_ERRCH, 32'h3);
      exp("clrwin_outs", S_OUTS, 32'h0500_0000);
      drive(1'b0, 0, 1'b0, 0, 1'b1);
      drive(1'b1, 3, 1'b1, 0);
      exp("both_ovf", S_OVF, 32'h1);
      exp("both_udf", S_UDF, 32'h1);
      exp("both_errch", S_ERRCH, 32'h3);
      // reset during traffic
      drive(1'b1, 1, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_reset("midrst");
      @(negedge clk);
      rst = 1'b0;
      cmd = 1'b0;
      outs_max = 8'd0;
      exp("max0_full", S_FULL, 32'hF);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d checks pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
